// File: rtl/rf_read_port_arbiter_pkg.sv
// Shared constants for the register-file read-port arbiter: FSM encoding and
// default datapath widths of the 32-entry register file.
package rf_read_port_arbiter_pkg;

    localparam logic [0:0] STATE_IDLE = 1'b0;
    localparam logic [0:0] STATE_LOCK = 1'b1;

    localparam int RF_AW = 5;
    localparam int RF_DW = 32;

endpackage

// File: rtl/rf_read_port_arbiter_if.sv
// Request/grant/response bundle between the requesters plus external read mux
// (master side) and the arbiter (slave side).
interface rf_read_port_arbiter_if
    import rf_read_port_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int AW   = RF_AW,
    parameter int DW   = RF_DW
) ();

    logic                 stall;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ-1:0]      req_lock;
    logic [NREQ-1:0]      req_ready;
    logic [AW-1:0]        rd_sel;
    logic [DW-1:0]        rd_data;
    logic [NREQ-1:0]      resp_valid;
    logic [DW-1:0]        resp_data;

    modport master (
        output stall, req_valid, req_addr, req_lock, rd_data,
        input  req_ready, rd_sel, resp_valid, resp_data
    );

    modport slave (
        input  stall, req_valid, req_addr, req_lock, rd_data,
        output req_ready, rd_sel, resp_valid, resp_data
    );

endinterface

// File: rtl/rf_read_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of req searching upward
// from ptr, wrapping modulo NREQ.
module rf_read_port_arbiter_rr_pick #(
    parameter int NREQ = 4,
    localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   idx,
    output logic            any
);

    int j;

    // Walk offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (req[j]) begin
                grant    = '0;
                grant[j] = 1'b1;
                idx      = PW'(j);
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rf_read_port_arbiter.sv
// Round-robin arbiter sharing one register-file read mux between NREQ
// requesters, with an optional one-cycle lock for paired operand reads.
//
// state | meaning
// IDLE  | round-robin grant from rr_ptr
// LOCK  | only lock_owner may be granted this cycle, then back to IDLE
module rf_read_port_arbiter
    import rf_read_port_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int AW   = RF_AW,
    parameter int DW   = RF_DW
) (
    input  logic                  clk,
    input  logic                  rst_n,
    rf_read_port_arbiter_if.slave bus
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [0:0]      state;
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   lock_owner;
    logic [PW-1:0]   pick_idx;
    logic [PW-1:0]   grant_idx;
    logic [PW-1:0]   ptr_next;
    logic [NREQ-1:0] pick_grant;
    logic [NREQ-1:0] grant;
    logic            pick_any;

    rf_read_port_arbiter_rr_pick #(
        .NREQ (NREQ)
    ) u_rr_pick (
        .req   (bus.req_valid),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    always_comb begin
        grant     = '0;
        grant_idx = pick_idx;
        if (rst_n && !bus.stall) begin
            if (state == STATE_IDLE) begin
                grant = pick_grant;
            end else if (bus.req_valid[lock_owner]) begin
                grant[lock_owner] = 1'b1;
                grant_idx         = lock_owner;
            end
        end
    end

    assign bus.req_ready = grant;
    assign bus.rd_sel    = (|grant) ? bus.req_addr[int'(grant_idx)*AW +: AW] : '0;
    assign ptr_next      = (pick_idx == PW'(NREQ - 1)) ? '0 : pick_idx + PW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= STATE_IDLE;
            rr_ptr         <= '0;
            lock_owner     <= '0;
            bus.resp_valid <= '0;
            bus.resp_data  <= '0;
        end else begin
            bus.resp_valid <= grant;
            if (|grant) begin
                bus.resp_data <= bus.rd_data;
            end
            // A lock lasts exactly one cycle whether or not it is used.
            if (state == STATE_LOCK) begin
                state <= STATE_IDLE;
            end else if (!bus.stall && pick_any) begin
                rr_ptr <= ptr_next;
                if (bus.req_lock[pick_idx]) begin
                    state      <= STATE_LOCK;
                    lock_owner <= pick_idx;
                end
            end
        end
    end

endmodule

// File: tb/tb_rf_read_port_arbiter.sv
// Directed bench for rf_read_port_arbiter with a behavioural arbitration model
// and a register-file mux whose entry i holds the value i.
module tb_rf_read_port_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 5;
    localparam int DW   = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rf_read_port_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

    rf_read_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [DW-1:0] mem [32];
    assign bus.rd_data = mem[bus.rd_sel];

    int checks = 0;
    int errors = 0;

    logic [NREQ-1:0] v, lk;
    logic            st;
    int              addr [NREQ];

    int              m_ptr, m_owner;
    logic [NREQ-1:0] m_rv;
    logic [DW-1:0]   m_rd;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic apply();
        bus.req_valid = v;
        bus.req_lock  = lk;
        bus.stall     = st;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_addr[i*AW +: AW] = AW'(addr[i]);
        end
    endtask

    function automatic int model_grant();
        if (st) return -1;
        if (m_owner >= 0) return v[m_owner] ? m_owner : -1;
        for (int k = 0; k < NREQ; k++) begin
            if (v[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr   = 0;
        m_owner = -1;
        m_rv    = '0;
        m_rd    = '0;
    endtask

    // One clock cycle: drive, compare against the model, advance the model.
    // lit_* are hand-computed expectations, skipped when negative.
    task automatic cycle(input int lit_rdy, input int lit_rv, input int lit_rd);
        int g;
        apply();
        #1;
        g = model_grant();
        chk("req_ready", int'(bus.req_ready), (g < 0) ? 0 : (1 << g));
        chk("rd_sel", int'(bus.rd_sel), (g < 0) ? 0 : addr[g]);
        chk("resp_valid", int'(bus.resp_valid), int'(m_rv));
        chk("resp_data", int'(bus.resp_data), int'(m_rd));
        if (lit_rdy >= 0) chk("lit_req_ready", int'(bus.req_ready), lit_rdy);
        if (lit_rv >= 0)  chk("lit_resp_valid", int'(bus.resp_valid), lit_rv);
        if (lit_rd >= 0)  chk("lit_resp_data", int'(bus.resp_data), lit_rd);
        @(posedge clk);
        if (m_owner >= 0) begin
            m_owner = -1;
        end else if (g >= 0) begin
            m_ptr = (g + 1) % NREQ;
            if (lk[g]) m_owner = g;
        end
        m_rv = '0;
        if (g >= 0) begin
            m_rv[g] = 1'b1;
            m_rd    = mem[addr[g]];
        end
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = DW'(i);
        addr[0] = 5; addr[1] = 9; addr[2] = 20; addr[3] = 31;
        v = '1; lk = '0; st = 1'b0;
        rst_n = 1'b0;
        apply();
        model_reset();
        #2;
        chk("rst_req_ready", int'(bus.req_ready), 0);
        chk("rst_rd_sel", int'(bus.rd_sel), 0);
        chk("rst_resp_valid", int'(bus.resp_valid), 0);
        chk("rst_resp_data", int'(bus.resp_data), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Round robin, all requesting
        cycle(1, 0, -1);
        cycle(2, 1, 5);
        cycle(4, 2, 9);
        cycle(8, 4, 20);
        cycle(1, 8, 31);
        cycle(2, 1, 5);

        // Stall freezes the grant order
        st = 1'b1;
        cycle(0, 2, 9);
        cycle(0, 0, -1);
        cycle(0, 0, 9);
        st = 1'b0;
        cycle(4, 0, 9);
        cycle(8, 4, 20);

        // Lock on requester 2, no chaining while req_lock stays high
        v = 4'b1100; lk = 4'b0100;
        cycle(4, 8, 31);
        cycle(4, 4, 20);
        cycle(8, 4, 20);
        cycle(4, 8, 31);
        cycle(4, 4, 20);
        cycle(8, 4, 20);

        // Stall during the lock cycle forfeits it
        cycle(4, -1, -1);
        st = 1'b1;
        cycle(0, -1, -1);
        st = 1'b0; lk = '0;
        cycle(8, -1, -1);

        // Lock forfeited by dropping req_valid
        v = 4'b0010; lk = 4'b0010;
        cycle(2, -1, -1);
        v = 4'b0001;
        cycle(0, 2, 9);
        lk = '0;
        cycle(1, 0, 9);

        // Sparse: only requester 3, back-to-back reads including address 0
        v = 4'b1000; addr[3] = 31;
        cycle(8, 1, 5);
        addr[3] = 0;
        cycle(8, 8, 31);
        addr[3] = 17;
        cycle(8, 8, 0);
        v = '0;
        cycle(0, 8, 17);

        // Reset with a response on the outputs
        v = '1;
        cycle(1, 0, 17);
        #1;
        chk("pre_rst_resp_valid", int'(bus.resp_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_resp_valid", int'(bus.resp_valid), 0);
        chk("mid_rst_resp_data", int'(bus.resp_data), 0);
        chk("mid_rst_req_ready", int'(bus.req_ready), 0);
        chk("mid_rst_rd_sel", int'(bus.rd_sel), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1, 0, 0);
        cycle(2, 1, 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
